// File: rtl/move_dispatcher.sv
// move_dispatcher: queues 4-bit solver moves and issues one registered cw/ccw pulse per move, then waits
// for the synchronised Arduino done edge and a fixed gap; DISPATCH_TIMEOUT_EN adds a WAIT_DONE watchdog.
module move_dispatcher #(
  parameter int N_FACES        = 6,
  parameter int DEPTH          = 16,
  parameter int PULSE_CYCLES   = 100,
  parameter int GAP_CYCLES     = 50,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               move_valid,
  input  logic [3:0]         move_code,
  output logic               move_ready,
  output logic [N_FACES-1:0] cw,
  output logic [N_FACES-1:0] ccw,
  input  logic               motor_done,
  output logic               busy,
  output logic               err_code,
  output logic               err_timeout,
  output logic [15:0]        moves_done
);

  localparam int AW      = $clog2(DEPTH);
  localparam int MAX_PG  = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int MAX_CNT = (MAX_PG > TIMEOUT_CYCLES) ? MAX_PG : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PULSE     = 2'd1,
    WAIT_DONE = 2'd2,
    GAP       = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         face_q, face_d;
  logic               dir_q, dir_d;
  logic [N_FACES-1:0] cw_q, cw_d, ccw_q, ccw_d;
  logic               busy_q, busy_d;
  logic               err_code_q, err_code_d;
  logic [15:0]        moves_q, moves_d;
  logic               sync1_q, sync2_q, done_prev_q, done_rise;

  logic [3:0]         mem_q [DEPTH];
  logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [AW:0]        count_q;
  logic               full, empty, push, pop, head_bad;
  logic [3:0]         head;

  assign full       = (count_q == (AW+1)'(DEPTH));
  assign empty      = (count_q == '0);
  assign push       = move_valid && !full;
  assign move_ready = !full;
  assign head       = mem_q[rd_ptr_q];
  assign head_bad   = (32'(head[2:0]) >= N_FACES);

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= move_code;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // motor_done is asynchronous: two flops, then a free-running rising-edge detector
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      done_prev_q <= 1'b0;
    end else begin
      sync1_q     <= motor_done;
      sync2_q     <= sync1_q;
      done_prev_q <= sync2_q;
    end
  end

  assign done_rise = sync2_q && !done_prev_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

`ifdef DISPATCH_TIMEOUT_EN
  logic err_to_q, err_to_d;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pop        = 1'b0;
    face_d     = face_q;
    dir_d      = dir_q;
    err_code_d = err_code_q;
    moves_d    = moves_q;
`ifdef DISPATCH_TIMEOUT_EN
    err_to_d   = err_to_q;
`endif
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop = 1'b1;
          if (head_bad) begin
            err_code_d = 1'b1;
          end else begin
            face_d  = head[2:0];
            dir_d   = head[3];
            cnt_d   = CNT_W'(PULSE_CYCLES);
            state_d = PULSE;
          end
        end
      end
      PULSE: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = WAIT_DONE;
`ifdef DISPATCH_TIMEOUT_EN
          cnt_d   = CNT_W'(TIMEOUT_CYCLES);
`endif
        end
      end
      WAIT_DONE: begin
        if (done_rise) begin
          moves_d = moves_q + 16'd1;
          cnt_d   = CNT_W'(GAP_CYCLES);
          state_d = GAP;
        end
`ifdef DISPATCH_TIMEOUT_EN
        else if (cnt_q == CNT_W'(1)) begin
          err_to_d = 1'b1;
          cnt_d    = CNT_W'(GAP_CYCLES);
          state_d  = GAP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
`endif
      end
      GAP: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Command lines are decoded from the current state and registered, so they trail PULSE by one edge
  always_comb begin
    cw_d   = '0;
    ccw_d  = '0;
    busy_d = (state_q != IDLE) || !empty;
    if (state_q == PULSE) begin
      if (dir_q) ccw_d = N_FACES'(1) << face_q;
      else       cw_d  = N_FACES'(1) << face_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      face_q     <= '0;
      dir_q      <= 1'b0;
      cw_q       <= '0;
      ccw_q      <= '0;
      busy_q     <= 1'b0;
      err_code_q <= 1'b0;
      moves_q    <= '0;
    end else begin
      cnt_q      <= cnt_d;
      face_q     <= face_d;
      dir_q      <= dir_d;
      cw_q       <= cw_d;
      ccw_q      <= ccw_d;
      busy_q     <= busy_d;
      err_code_q <= err_code_d;
      moves_q    <= moves_d;
    end
  end

`ifdef DISPATCH_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) err_to_q <= 1'b0;
    else     err_to_q <= err_to_d;
  end
  assign err_timeout = err_to_q;
`else
  assign err_timeout = 1'b0;
`endif

  assign cw         = cw_q;
  assign ccw        = ccw_q;
  assign busy       = busy_q;
  assign err_code   = err_code_q;
  assign moves_done = moves_q;

endmodule

// File: tb/tb_move_dispatcher.sv
// Bench for move_dispatcher: timestamp-based reference model checked every cycle, plus directed scenarios.
module tb_move_dispatcher;
  localparam int NF = 6;
  localparam int DP = 4;
  localparam int PC = 4;
  localparam int GC = 2;
  localparam int TC = 20;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          move_valid = 1'b0;
  logic [3:0]    move_code = 4'd0;
  logic          motor_done = 1'b0;
  logic          move_ready, busy, err_code, err_timeout;
  logic [NF-1:0] cw, ccw;
  logic [15:0]   moves_done;

  move_dispatcher #(
    .N_FACES(NF), .DEPTH(DP), .PULSE_CYCLES(PC), .GAP_CYCLES(GC), .TIMEOUT_CYCLES(TC)
  ) dut (
    .clk(clk), .rst(rst), .move_valid(move_valid), .move_code(move_code),
    .move_ready(move_ready), .cw(cw), .ccw(ccw), .motor_done(motor_done),
    .busy(busy), .err_code(err_code), .err_timeout(err_timeout), .moves_done(moves_done)
  );

  always #5 clk = ~clk;

  // Reference model: absolute edge timestamps, one step per rising edge
  int            cyc = -1;
  int            last_rst = -1000;
  bit            md_at[$];
  int            mq[$];
  int            ph = 0;        // 0 idle, 1 move in progress, 2 gap
  int            t0 = -1000;    // edge at which the current move was popped
  int            gap_end = 0;
  int            m_done = 0;
  bit            m_errc = 0, m_errt = 0, m_busy = 0, m_ok = 0, e_rdy = 1;
  int            m_face = 0;
  bit            m_dir = 0;
  logic [NF-1:0] e_cw = '0, e_ccw = '0;

  function automatic bit rise_at(int e);
    if (e - 2 <= last_rst) return 1'b0;
    if (!md_at[e-2]) return 1'b0;
    if (e - 3 <= last_rst) return 1'b1;
    return !md_at[e-3];
  endfunction

  always @(posedge clk) begin
    bit pre_busy;
    bit full;
    int c;
    cyc++;
    md_at.push_back(motor_done);
    pre_busy = (ph != 0) || (mq.size() != 0);
    if (rst) begin
      mq.delete();
      ph = 0; t0 = -1000; m_done = 0; m_errc = 0; m_errt = 0; m_busy = 0;
      last_rst = cyc; m_ok = 1;
    end else begin
      full = (mq.size() == DP);
      case (ph)
        0: if (mq.size() != 0) begin
          c = mq.pop_front();
          if ((c % 8) >= NF) m_errc = 1;
          else begin ph = 1; t0 = cyc; m_face = c % 8; m_dir = (c >= 8); end
        end
        1: if (cyc > t0 + PC) begin
          if (rise_at(cyc)) begin m_done++; ph = 2; gap_end = cyc + GC; end
`ifdef DISPATCH_TIMEOUT_EN
          else if (cyc == t0 + PC + TC) begin m_errt = 1; ph = 2; gap_end = cyc + GC; end
`endif
        end
        default: if (cyc == gap_end) ph = 0;
      endcase
      if (move_valid && !full) mq.push_back(int'(move_code));
      m_busy = pre_busy;
    end
    e_cw = '0;
    e_ccw = '0;
    if (cyc >= t0 + 1 && cyc <= t0 + PC) begin
      if (m_dir) e_ccw[m_face] = 1'b1;
      else       e_cw[m_face]  = 1'b1;
    end
    e_rdy = (mq.size() < DP);
  end

  int            checks = 0, failures = 0;
  int            issued[$];
  int            hi_cnt[2*NF], first_hi[2*NF], last_hi[2*NF];
  logic [2*NF-1:0] rec_prev = '0;
  bit            auto_resp = 0, cmd_was = 0;
  int            resp_cnt = 0, hold = 0;
  int            p, idx, n;
  int            codes[6] = '{0, 1, 2, 3, 4, 5};

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, want %0d (edge %0d)", nm, act, exp, cyc);
    end
  endtask

  // One cycle: compare against the model, record pulses, run the Arduino responder
  task automatic tick();
    logic [2*NF-1:0] vec;
    @(negedge clk);
    if (m_ok) begin
      chk("cw", 32'(cw), 32'(e_cw));
      chk("ccw", 32'(ccw), 32'(e_ccw));
      chk("move_ready", 32'(move_ready), 32'(e_rdy));
      chk("busy", 32'(busy), 32'(m_busy));
      chk("err_code", 32'(err_code), 32'(m_errc));
      chk("err_timeout", 32'(err_timeout), 32'(m_errt));
      chk("moves_done", 32'(moves_done), 32'(m_done & 16'hFFFF));
    end
    vec = {ccw, cw};
    for (int i = 0; i < 2*NF; i++) begin
      if (vec[i] && !rec_prev[i]) begin issued.push_back(i); first_hi[i] = cyc; end
      if (vec[i]) begin hi_cnt[i]++; last_hi[i] = cyc; end
    end
    rec_prev = vec;
    if (auto_resp) begin
      if (hold > 0) begin
        hold--;
        if (hold == 0) motor_done = 1'b0;
      end else if (resp_cnt > 0) begin
        resp_cnt--;
        if (resp_cnt == 0) begin motor_done = 1'b1; hold = $urandom_range(1, 3); end
      end
      if (cmd_was && vec == '0) resp_cnt = $urandom_range(1, 8);
    end
    cmd_was = (vec != '0);
  endtask

  task automatic clear_rec();
    issued.delete();
    for (int i = 0; i < 2*NF; i++) begin hi_cnt[i] = 0; first_hi[i] = -1; last_hi[i] = -1; end
  endtask

  task automatic do_reset();
    rst = 1'b1; move_valid = 1'b0; motor_done = 1'b0;
    auto_resp = 0; resp_cnt = 0; hold = 0;
    tick(); tick();
    rst = 1'b0;
    clear_rec();
  endtask

  task automatic push1(int code);
    move_valid = 1'b1; move_code = 4'(code);
    tick();
    move_valid = 1'b0;
  endtask

  task automatic wait_idle(string nm, int budget);
    int k = 0;
    while (busy && k < budget) begin tick(); k++; end
    chk(nm, 32'(busy), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // reset values
    rst = 1'b1;
    tick(); tick();
    chk("rst_cw", 32'(cw), 0);
    chk("rst_ccw", 32'(ccw), 0);
    chk("rst_ready", 32'(move_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_moves", 32'(moves_done), 0);
    chk("rst_err", 32'({err_code, err_timeout}), 0);

    // single clockwise move, done raised 10 edges after the push
    do_reset();
    push1(2); p = cyc;
    while (cyc < p + 9) tick();
    motor_done = 1'b1; tick(); tick(); motor_done = 1'b0;
    while (cyc < p + 17) tick();
    chk("single_first", first_hi[2], p + 2);
    chk("single_last", last_hi[2], p + 5);
    chk("single_width", hi_cnt[2], 4);
    chk("single_lines", issued.size(), 1);
    chk("single_moves", 32'(moves_done), 1);
    chk("single_busy", 32'(busy), 0);

    // anticlockwise bottom
    do_reset();
    push1(4'hD); p = cyc;
    while (cyc < p + 9) tick();
    motor_done = 1'b1; tick(); tick(); motor_done = 1'b0;
    while (cyc < p + 17) tick();
    chk("ccw_first", first_hi[NF+5], p + 2);
    chk("ccw_width", hi_cnt[NF+5], 4);
    chk("ccw_lines", issued.size(), 1);

    // FIFO full while the first move waits for done
    do_reset();
    idx = 0;
    for (int k = 0; k < 12; k++) begin
      bit rdy;
      move_valid = (idx < 6);
      move_code = 4'(codes[idx % 6]);
      rdy = move_ready;
      tick();
      if (move_valid && rdy) idx++;
    end
    chk("full_accepted", idx, 5);
    chk("full_ready", 32'(move_ready), 0);
    motor_done = 1'b1;
    for (int k = 0; k < 40 && idx < 6; k++) begin
      bit rdy;
      if (k == 2) motor_done = 1'b0;
      move_valid = 1'b1; move_code = 4'(codes[idx % 6]);
      rdy = move_ready;
      tick();
      if (rdy) idx++;
    end
    move_valid = 1'b0; motor_done = 1'b0;
    chk("full_last_accepted", idx, 6);
    auto_resp = 1;
    tick(); tick();
    wait_idle("full_drain", 500);
    chk("full_order_n", issued.size(), 6);
    for (int i = 0; i < 6; i++)
      chk("full_order", (i < issued.size()) ? issued[i] : -1, codes[i]);
    chk("full_moves", 32'(moves_done), 6);

    // invalid face then a valid one
    do_reset();
    push1(7); push1(0);
    auto_resp = 1;
    tick(); tick();
    wait_idle("inv_drain", 200);
    chk("inv_err", 32'(err_code), 1);
    chk("inv_lines", issued.size(), 1);
    chk("inv_face", (issued.size() > 0) ? issued[0] : -1, 0);
    chk("inv_width", hi_cnt[0], 4);
    chk("inv_moves", 32'(moves_done), 1);

    // reset during the second PULSE cycle with two moves queued
    do_reset();
    push1(1); push1(3); push1(4);
    n = 0;
    while ((cw | ccw) == '0 && n < 20) begin tick(); n++; end
    tick();
    rst = 1'b1;
    tick();
    chk("rstp_cw", 32'(cw), 0);
    chk("rstp_ccw", 32'(ccw), 0);
    rst = 1'b0;
    clear_rec();
    repeat (30) tick();
    chk("rstp_lines", issued.size(), 0);
    chk("rstp_ready", 32'(move_ready), 1);
    chk("rstp_busy", 32'(busy), 0);

    // Arduino never answers
    do_reset();
    push1(4); push1(8);
    repeat (60) tick();
    chk("to_moves", 32'(moves_done), 0);
`ifdef DISPATCH_TIMEOUT_EN
    chk("to_err", 32'(err_timeout), 1);
    chk("to_lines", issued.size(), 2);
    chk("to_second", (issued.size() > 1) ? issued[1] : -1, NF + 0);
`else
    chk("to_err", 32'(err_timeout), 0);
    chk("to_lines", issued.size(), 1);
    chk("to_busy", 32'(busy), 1);
`endif

    // randomized traffic with an automatic responder
    do_reset();
    auto_resp = 1;
    for (int k = 0; k < 1500; k++) begin
      move_valid = ($urandom_range(0, 3) == 0);
      move_code = 4'($urandom_range(0, 15));
      tick();
    end
    move_valid = 1'b0;
    tick(); tick();
    wait_idle("rand_drain", 3000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
